hello_rx: RTL and testbench

HELLO_RX -- requirements
Module: hello_rx

---
 rtl/hello_rx.sv | 59 +++++
 tb/tb_hello_rx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hello_rx.sv
// hello_rx: streaming byte matcher that detects the message "Hello, world!"
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   in_valid      - a byte is presented on in_data
//   in_data       - 8-bit ASCII byte
//   in_ready      - byte accepted when high together with in_valid
//   clear         - synchronous clear of the matcher state and the counters
//   match         - one-cycle pulse after the final '!' of a message transfers
//   match_count   - saturating count of complete messages
//   miss_count    - saturating count of bytes that broke a partial match
//   idx           - number of message bytes matched so far (0..12)
module hello_rx #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               clear,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic [COUNT_W-1:0] miss_count,
    output logic [3:0]         idx
);
    localparam int MSG_LEN = 13;
    localparam logic [7:0] MSG [MSG_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
        8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21
    };
    logic xfer, hit, last;
    assign in_ready = rst_n && !clear;
    always_comb begin
        xfer = in_valid && in_ready;
        hit  = in_data == MSG[idx];
        last = idx == 4'(MSG_LEN - 1);
    end
    // 'H' appears only at position 0, so a mismatch either restarts at 1 or drops to 0
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            idx         <= '0;
            match       <= 1'b0;
            match_count <= '0;
            miss_count  <= '0;
        end else begin
            match <= xfer && hit && last;
            if (xfer) begin
                if (hit)
                    idx <= last ? 4'd0 : idx + 4'd1;
                else
                    idx <= (in_data == MSG[0]) ? 4'd1 : 4'd0;
                if (hit && last && match_count != '1)
                    match_count <= match_count + COUNT_W'(1);
                if (!hit && idx != '0 && miss_count != '1)
                    miss_count <= miss_count + COUNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hello_rx.sv
// tb_hello_rx: scoreboard bench for hello_rx against a suffix-matching reference model
module tb_hello_rx;
    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 0, rst_n = 0, in_valid = 0, clear = 0;
    logic [7:0]    in_data = 0;
    logic          in_ready, match;
    logic [CW-1:0] match_count, miss_count;
    logic [3:0]    idx;

    always #5 clk = ~clk;

    hello_rx #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .match(match),
        .match_count(match_count), .miss_count(miss_count), .idx(idx)
    );

    typedef struct {
        logic rdy;
        logic m;
        int   i;
        int   mc;
        int   mm;
    } exp_t;

    exp_t         q[$];
    byte unsigned msg[13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                              8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    byte unsigned hist[$];
    int           mc = 0, mm = 0, npulse = 0;
    int           compared = 0, mismatched = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endfunction

    // longest suffix of the accepted stream that is a prefix of the message
    function automatic int longest();
        int n = hist.size();
        for (int k = (n < 13 ? n : 13); k > 0; k--) begin
            bit ok = 1;
            for (int j = 0; j < k; j++)
                if (hist[n - k + j] != msg[j]) ok = 0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input byte unsigned d);
        exp_t e;
        int   old, nw;
        bit   m = 0;
        @(negedge clk);
        rst_n = r; clear = c; in_valid = v; in_data = d;
        e.rdy = r && !c;
        if (!r || c) begin
            hist.delete(); mc = 0; mm = 0;
        end else if (v) begin
            old = longest();
            hist.push_back(d);
            nw = longest();
            if (nw == 13) begin
                m = 1;
                hist.delete();
                if (mc < MAX) mc++;
            end else if (old > 0 && nw != old + 1 && mm < MAX) mm++;
            if (hist.size() > 12) void'(hist.pop_front());
        end
        e.m = m; e.i = longest(); e.mc = mc; e.mm = mm;
        q.push_back(e);
    endtask

    task automatic send_str(input string s, input bit toggle);
        for (int i = 0; i < s.len(); i++) begin
            step(1, 0, 1, s[i]);
            if (toggle) step(1, 0, 0, 8'($urandom));
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("in_ready", in_ready, e.rdy);
            chk("match", match, e.m);
            chk("idx", idx, e.i);
            chk("match_count", match_count, e.mc);
            chk("miss_count", miss_count, e.mm);
            if (match === 1'b1) npulse++;
        end
    end

    initial begin
        int base;
        repeat (3) step(0, 0, 1, "H");
        send_str("Hello, world!", 0);
        step(1, 0, 0, 0);
        send_str("HeHello, world!", 0);
        step(1, 1, 0, 0);
        send_str("Hello, World!", 0);
        step(1, 1, 0, 0);
        send_str("Hello, world!", 1);
        step(1, 1, 0, 0);
        base = npulse;
        repeat (5) send_str("Hello, world!", 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("pulses_5_msgs", npulse - base, 5);
        step(1, 1, 0, 0);
        send_str("Hello, ", 0);
        step(0, 0, 1, "w");
        send_str("Hello, world!", 0);
        step(1, 1, 0, 0);
        send_str("Hello, world", 0);
        step(1, 1, 1, "!");
        step(1, 0, 0, 0);
        send_str("Hello, wor", 0);
        step(0, 1, 1, "l");
        step(1, 0, 1, 8'hC8);
        send_str("Hello, world!", 0);
        for (int n = 0; n < 2000; n++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 3) send_str("Hello, world!", $urandom_range(0, 1) == 1);
            else if (sel < 5) step(1, 1, $urandom_range(0, 1) == 1, msg[$urandom_range(0, 12)]);
            else if (sel < 6) step(0, $urandom_range(0, 1) == 1, 1, msg[$urandom_range(0, 12)]);
            else if (sel < 20) step(1, 0, 0, 8'($urandom));
            else if (sel < 30) step(1, 0, 1, 8'($urandom));
            else if (sel < 35) step(1, 0, 1, msg[$urandom_range(0, 12)] ^ 8'h80);
            else step(1, 0, 1, msg[$urandom_range(0, 12)]);
        end
        step(1, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
